// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector: programmable pattern/length, overlap mode,
// registered match pulse and saturating match counter.
module seq_detect_param #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               cnt_sat,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic               overlap;

  logic [MAX_LEN-1:0] hist_nxt;
  logic [LEN_W-1:0]   fill_nxt;
  logic [MAX_LEN-1:0] mask;
  logic               hit;
  logic               cfg_ok;
  logic               beat;

  always_comb begin
    hist_nxt = {hist[MAX_LEN-2:0], in_bit};
    fill_nxt = (fill == LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;
    mask     = '0;
    for (int i = 0; i < MAX_LEN; i++)
      mask[i] = (LEN_W'(i) < len);
    // only the low len bits of history and pattern take part
    hit    = (fill_nxt >= len) &&
             (((hist_nxt ^ pattern) & mask) == '0);
    cfg_ok = (cfg_len >= LEN_W'(2)) &&
             (cfg_len <= LEN_W'(MAX_LEN));
    beat   = in_valid && !cfg_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist        <= '0;
      fill        <= '0;
      pattern     <= MAX_LEN'(5);
      len         <= LEN_W'(3);
      overlap     <= 1'b1;
      match       <= 1'b0;
      match_count <= '0;
      cnt_sat     <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      match   <= 1'b0;
      cfg_err <= 1'b0;
      if (cfg_we) begin
        if (cfg_ok) begin
          pattern <= cfg_pattern;
          len     <= cfg_len;
          overlap <= cfg_overlap;
          hist    <= '0;
          fill    <= '0;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (in_valid) begin
        hist  <= hist_nxt;
        // non-overlap: restart filling so matched bits are not reused
        fill  <= (hit && !overlap) ? '0 : fill_nxt;
        match <= hit;
      end
      if (cnt_clr) begin
        match_count <= '0;
        cnt_sat     <= 1'b0;
      end else if (beat && hit) begin
        if (match_count == {CNT_W{1'b1}})
          cnt_sat <= 1'b1;
        else
          match_count <= match_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: default (CNT_W=8) and CNT_W=2
// instances share stimulus; checks use immediate assertions.
module tb_seq_detect_param;

  localparam int ML = 8;
  localparam int LW = $clog2(ML) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [ML-1:0] cfg_pattern;
  logic [LW-1:0] cfg_len;
  logic          cfg_overlap;
  logic          cnt_clr;
  logic          in_valid;
  logic          in_bit;

  logic          m8, s8, e8;
  logic [7:0]    c8;
  logic          m2, s2, e2;
  logic [1:0]    c2;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.MAX_LEN(ML), .CNT_W(8)) d8 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_bit(in_bit),
    .match(m8), .match_count(c8),
    .cnt_sat(s8), .cfg_err(e8)
  );

  seq_detect_param #(.MAX_LEN(ML), .CNT_W(2)) d2 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_bit(in_bit),
    .match(m2), .match_count(c2),
    .cnt_sat(s2), .cfg_err(e2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    step();
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic cfg(input logic [LW-1:0] l,
                     input logic [ML-1:0] p,
                     input logic o,
                     input logic v,
                     input logic b);
    cfg_we      = 1'b1;
    cfg_len     = l;
    cfg_pattern = p;
    cfg_overlap = o;
    in_valid    = v;
    in_bit      = b;
    step();
    cfg_we   = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic clr();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
  endtask

  logic [7:0] a5;
  int gaps[8];

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0;
    cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
    in_valid = 1'b1; in_bit = 1'b1;
    idle(2);
    chk("rst_match", m8, 0);
    chk("rst_count", c8, 0);
    chk("rst_sat", s8, 0);
    chk("rst_err", e8, 0);
    rst = 1'b0; in_valid = 1'b0; in_bit = 1'b0;

    // default "101" overlapping
    beat(1); chk("d_b1", m8, 0);
    beat(0); chk("d_b2", m8, 0);
    beat(1); chk("d_b3", m8, 1);
    beat(0); chk("d_b4", m8, 0);
    beat(1); chk("d_b5", m8, 1);
    chk("d_cnt", c8, 2);
    idle(1); chk("d_idle", m8, 0);
    chk("d_idle_cnt", c8, 2);

    // bad cfg len=0 with a dropped 0 bit
    cfg(0, 8'h00, 0, 1, 0);
    chk("bad0_err", e8, 1);
    chk("bad0_m", m8, 0);
    idle(1); chk("bad0_err_end", e8, 0);
    beat(1); chk("drop_b", m8, 0);
    beat(0); chk("drop_b0", m8, 0);
    beat(1); chk("drop_b1", m8, 1);
    chk("drop_cnt", c8, 3);
    cfg(9, 8'h00, 0, 0, 0);
    chk("bad9_err", e8, 1);
    idle(1); chk("bad9_err_end", e8, 0);
    beat(0); chk("bad9_b0", m8, 0);
    beat(1); chk("bad9_b1", m8, 1);
    chk("bad9_cnt", c8, 4);

    // non-overlap "101"
    clr(); chk("clr_cnt", c8, 0);
    cfg(3, 8'h05, 0, 1, 1);
    chk("ok_err", e8, 0);
    beat(1); chk("no_b1", m8, 0);
    beat(0); chk("no_b2", m8, 0);
    beat(1); chk("no_b3", m8, 1);
    beat(0); chk("no_b4", m8, 0);
    beat(1); chk("no_b5", m8, 0);
    chk("no_cnt1", c8, 1);
    beat(0); chk("no_b6", m8, 0);
    beat(1); chk("no_b7", m8, 1);
    chk("no_cnt2", c8, 2);

    // len 8, A5, with gaps
    cfg(8, 8'hA5, 1, 0, 0);
    a5 = 8'hA5;
    gaps = '{0, 1, 0, 3, 2, 0, 1, 0};
    for (int i = 7; i >= 0; i--) begin
      beat(a5[i]);
      chk("a5_beat", m8, (i == 0) ? 1 : 0);
      in_bit = ~a5[i];
      idle(gaps[i]);
      if (gaps[i] != 0) chk("a5_gap", m8, 0);
      in_bit = 1'b0;
    end
    idle(2); chk("a5_after", m8, 0);
    chk("a5_cnt", c8, 3);
    chk("a5_cnt2", c2, 3);
    chk("a5_sat2", s2, 0);

    // saturation on CNT_W=2
    cfg(3, 8'h05, 1, 0, 0);
    clr(); chk("sat_clr", c2, 0);
    beat(1); beat(0);
    beat(1); chk("sat_c1", c2, 1);
    beat(0);
    beat(1); chk("sat_c2", c2, 2);
    beat(0);
    beat(1); chk("sat_c3", c2, 3);
    chk("sat_s3", s2, 0);
    beat(0);
    beat(1); chk("sat_c4", c2, 3);
    chk("sat_s4", s2, 1);
    chk("sat_c8", c8, 4);
    beat(0);
    cnt_clr = 1'b1;
    beat(1);
    cnt_clr = 1'b0;
    chk("clrm_match", m8, 1);
    chk("clrm_c8", c8, 0);
    chk("clrm_c2", c2, 0);
    chk("clrm_s2", s2, 0);

    // reset mid-stream
    beat(1); beat(0);
    rst = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    chk("mrst_m", m8, 0);
    chk("mrst_c", c8, 0);
    beat(1); chk("mrst_b1", m8, 0);
    beat(1); chk("mrst_b2", m8, 0);
    beat(0); chk("mrst_b3", m8, 0);
    beat(1); chk("mrst_b4", m8, 1);
    chk("mrst_cnt", c8, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL provide parameter MAX_LEN, default 8, meaning maximum pattern length in bits (legal 2..32).
REQ-002 SHALL provide parameter CNT_W, default 8, meaning width of the match counter.
REQ-003 SHALL derive localparam LEN_W = clog2(MAX_LEN)+1 for the length fields.
REQ-004 SHALL have clk  input  1  clock; all state changes occur on its rising edge.
REQ-005 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have cfg_we  input  1  configuration write strobe.
REQ-007 SHALL have cfg_pattern  input  MAX_LEN  pattern; bit len-1 is the first-received bit, bit 0 the last.
REQ-008 SHALL have cfg_len  input  LEN_W  pattern length in bits.
REQ-009 SHALL have cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-010 SHALL have cnt_clr  input  1  synchronous clear of match_count and cnt_sat.
REQ-011 SHALL have in_valid  input  1  qualifies in_bit; bits are consumed only when high.
REQ-012 SHALL have in_bit  input  1  serial data bit.
REQ-013 SHALL have match  output  1  registered Moore-style detect pulse.
REQ-014 SHALL have match_count  output  CNT_W  saturating count of detected matches.
REQ-015 SHALL have cnt_sat  output  1  sticky flag: match_count has saturated.
REQ-016 SHALL have cfg_err  output  1  one-cycle pulse: rejected configuration write.

Function
REQ-017 SHALL keep internal registers: hist (MAX_LEN-bit shift history), fill (0..MAX_LEN), active pattern/len/overlap.
REQ-018 SHALL, on an accepted beat (in_valid=1, cfg_we=0), shift hist left with in_bit entering bit 0 and set fill = min(fill+1, MAX_LEN).
REQ-019 SHALL detect a match on a beat when the post-shift fill >= len and the post-shift hist[len-1:0] equals pattern[len-1:0].
REQ-020 SHALL assert match for exactly one cycle, in the cycle after the completing beat (latency 1); match is 0 in all other cycles.
REQ-021 SHALL, in overlap mode, leave fill unchanged by a match, so pattern suffixes can seed the next match.
REQ-022 SHALL, in non-overlap mode, set fill to 0 on a match, so no bit of a matched pattern is reused.
REQ-023 SHALL hold hist, fill and match_count unchanged on cycles with in_valid=0; match deasserts.
REQ-024 SHALL increment match_count by 1 per match, saturating at 2^CNT_W-1, and set cnt_sat when an increment is attempted at saturation.
REQ-025 SHALL give cnt_clr priority over a same-cycle increment: count and cnt_sat become 0; match pulse is unaffected.
REQ-026 SHALL, on cfg_we with 2 <= cfg_len <= MAX_LEN, load pattern/len/overlap, clear hist, fill and match, and retain match_count.
REQ-027 SHALL, on cfg_we with cfg_len < 2 or cfg_len > MAX_LEN, keep the existing configuration, clear nothing, and pulse cfg_err for one cycle.
REQ-028 SHALL give cfg_we priority over in_valid in the same cycle; that in_bit is dropped and not counted.
REQ-029 SHALL ignore cfg_pattern bits at or above len.

Reset
REQ-030 SHALL, while rst=1, set match=0, match_count=0, cnt_sat=0, cfg_err=0, hist=0, fill=0, ignoring all other inputs.
REQ-031 SHALL reset the active configuration to pattern=...0101 (len=3, value 3'b101), overlap=1, giving "101" overlapping detection after reset.
REQ-032 SHALL abandon any partial sequence when rst is asserted mid-stream; detection restarts from empty history.

Verification
REQ-033 SHALL cover default config, beats 1,0,1,0,1 (in_valid continuous) -> match high in the cycle after beats 3 and 5; match_count=2.
REQ-034 SHALL cover cfg_overlap=0, len=3, pattern 101, beats 1,0,1,0,1 -> match only after beat 3; match_count=1; after a further 0,1, second match, count=2.
REQ-035 SHALL cover MAX_LEN=8, len=8, pattern 8'hA5, stream with in_valid gaps of 1-3 cycles inside the pattern -> single match after the 8th valid beat; gaps produce no match and no shift.
REQ-036 SHALL cover CNT_W=2 with 4 matches -> count holds at 3 and cnt_sat=1 after the 4th; cnt_clr then gives count=0 and cnt_sat=0.
REQ-037 SHALL cover cfg_we with cfg_len=0 and with cfg_len=MAX_LEN+1 -> cfg_err pulse for one cycle, "101" detection continues unchanged; a cfg_we coinciding with in_valid drops that bit.
REQ-038 SHALL cover rst asserted after beats 1,0 -> then beat 1 gives no match; a fresh 1,0,1 gives a match with count=1.
